// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter; one instance per requester.
// Handshake: req (with we/lock/addr/wdata) is held stable until gnt; an access transfers in the cycle req && gnt, and a read returns rvalid/rdata exactly one cycle later.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory with bounded locked bursts.
// Optional macro DMEM_ARB_RR_EN: round-robin collision resolution instead of fixed port-0 priority.
module dmem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              resetn,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [1:0]        owner
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Encoding doubles as the owner output, so owner is the visible FSM state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt, cnt_inc;
    logic             last_gnt, last_gnt_nxt;
    logic             gnt0, gnt1, win1, gnt_lock;
    logic             rvalid0, rvalid1;
`ifndef DMEM_ARB_RR_EN
    // Set by a forced release: the released port must lose the next collision.
    logic             yield, yield_nxt;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef DMEM_ARB_RR_EN
        win1 = ~last_gnt;
`else
        win1 = yield & ~last_gnt;
`endif
        if (resetn) begin
            case (state)
                IDLE: begin
                    gnt0 = m0.req & ~(m1.req & win1);
                    gnt1 = m1.req & ~gnt0;
                end
                OWN0:    gnt0 = m0.req;
                OWN1:    gnt1 = m1.req;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wd       = '0;
        gnt_lock     = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        last_gnt_nxt = last_gnt;
`ifndef DMEM_ARB_RR_EN
        yield_nxt    = yield;
`endif
        if (gnt0) begin
            mem_we   = m0.we;
            mem_addr = m0.addr;
            mem_wd   = m0.wdata;
            gnt_lock = m0.lock;
        end else if (gnt1) begin
            mem_we   = m1.we;
            mem_addr = m1.addr;
            mem_wd   = m1.wdata;
            gnt_lock = m1.lock;
        end
        cnt_inc = (state == IDLE) ? CNT_ONE :
                  (lock_cnt >= CNT_MAX) ? lock_cnt : lock_cnt + CNT_ONE;

        if (gnt0 | gnt1) begin
            last_gnt_nxt = gnt1;
`ifndef DMEM_ARB_RR_EN
            if (state == IDLE) yield_nxt = 1'b0;
`endif
            if (gnt_lock && cnt_inc < CNT_MAX) begin
                state_nxt    = gnt1 ? OWN1 : OWN0;
                lock_cnt_nxt = cnt_inc;
            end else begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
`ifndef DMEM_ARB_RR_EN
                if (gnt_lock) yield_nxt = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            lock_cnt <= '0;
            last_gnt <= 1'b1;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
`ifndef DMEM_ARB_RR_EN
            yield    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            last_gnt <= last_gnt_nxt;
            rvalid0  <= gnt0 & ~m0.we;
            rvalid1  <= gnt1 & ~m1.we;
`ifndef DMEM_ARB_RR_EN
            yield    <= yield_nxt;
`endif
        end
    end

    // Memory registers the read data itself, so only the port select is registered here.
    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rvalid0;
    assign m1.rvalid = rvalid1;
    assign m0.rdata  = rvalid0 ? mem_rd : '0;
    assign m1.rdata  = rvalid1 ? mem_rd : '0;
    assign owner     = state;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic against a reference model.
// Build with or without DMEM_ARB_RR_EN; expectations follow the same macro.
module tb_dmem_arbiter;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 8;

    logic              clk;
    logic              resetn;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic [1:0]        owner;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .owner    (owner)
    );

    // Clock and data-memory stand-in (1-cycle registered read, read-before-write).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_arr [512] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] <= mem_wd;
        mem_rd <= mem_arr[mem_addr];
    end

    // Reference model: who owns the bus, how many locked grants so far, fairness memory.
    int                n_checks = 0;
    int                n_fail   = 0;
    int                own, burst_len, last_win, must_yield;
    logic [DATA_W-1:0] ref_mem [512] = '{default: '0};
    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    logic              mg0, mg1, obs_g0, obs_g1;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own        = -1;
        burst_len  = 0;
        last_win   = 1;
        must_yield = -1;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_grant(input int p, input logic we, input logic lock,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (!we) begin
            if (p == 0) exp_q0.push_back(ref_mem[a]);
            else        exp_q1.push_back(ref_mem[a]);
        end else begin
            ref_mem[a] = d;
        end
        if (own < 0) must_yield = -1;
        last_win = p;
        if (lock) begin
            burst_len = (own < 0) ? 1 : burst_len + 1;
            if (burst_len >= LOCK_MAX) begin
                own        = -1;
                burst_len  = 0;
                must_yield = p;
            end else begin
                own = p;
            end
        end else begin
            own       = -1;
            burst_len = 0;
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic l,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            m0_bus.req = r; m0_bus.we = w; m0_bus.lock = l; m0_bus.addr = a; m0_bus.wdata = d;
        end else begin
            m1_bus.req = r; m1_bus.we = w; m1_bus.lock = l; m1_bus.addr = a; m1_bus.wdata = d;
        end
    endtask

    // One clock: predict at negedge, compare every output, advance model, return at posedge+1.
    task automatic cycle();
        logic              e_g0, e_g1, e_we, e_rv0, e_rv1;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd, e_rd0, e_rd1;
        logic [1:0]        e_own;
        int                win;
        @(negedge clk);
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (resetn) begin
            if (own == 0)      e_g0 = m0_bus.req;
            else if (own == 1) e_g1 = m1_bus.req;
            else if (m0_bus.req && m1_bus.req) begin
`ifdef DMEM_ARB_RR_EN
                win = 1 - last_win;
`else
                win = (must_yield == 0) ? 1 : 0;
`endif
                if (win == 0) e_g0 = 1'b1;
                else          e_g1 = 1'b1;
            end else begin
                e_g0 = m0_bus.req;
                e_g1 = m1_bus.req;
            end
        end
        e_we   = e_g0 ? m0_bus.we    : e_g1 ? m1_bus.we    : 1'b0;
        e_addr = e_g0 ? m0_bus.addr  : e_g1 ? m1_bus.addr  : '0;
        e_wd   = e_g0 ? m0_bus.wdata : e_g1 ? m1_bus.wdata : '0;
        e_own  = (own < 0) ? 2'b00 : (own == 0) ? 2'b01 : 2'b10;
        e_rv0  = exp_q0.size() > 0;
        e_rv1  = exp_q1.size() > 0;
        e_rd0  = e_rv0 ? exp_q0.pop_front() : '0;
        e_rd1  = e_rv1 ? exp_q1.pop_front() : '0;

        chk("gnt0", m0_bus.gnt, e_g0);
        chk("gnt1", m1_bus.gnt, e_g1);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wd", mem_wd, e_wd);
        chk("owner", owner, e_own);
        chk("rvalid0", m0_bus.rvalid, e_rv0);
        chk("rvalid1", m1_bus.rvalid, e_rv1);
        chk("rdata0", m0_bus.rdata, e_rd0);
        chk("rdata1", m1_bus.rdata, e_rd1);

        mg0    = e_g0;
        mg1    = e_g1;
        obs_g0 = m0_bus.gnt;
        obs_g1 = m1_bus.gnt;
        if (!resetn) model_reset();
        else if (e_g0) model_grant(0, m0_bus.we, m0_bus.lock, m0_bus.addr, m0_bus.wdata);
        else if (e_g1) model_grant(1, m1_bus.we, m1_bus.lock, m1_bus.addr, m1_bus.wdata);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int p1_cnt;
        int p0_cnt;
        model_reset();
        // Reset with both ports requesting: nothing may be granted.
        resetn = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 9'd1, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 9'd2, 32'h0);
        cycle();
        cycle();
        resetn = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Port 0 write then read-back of address 5.
        drive(0, 1'b1, 1'b1, 1'b0, 9'd5, 32'hA5A5A5A5);
        cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 9'd5, 32'h0);
        cycle();
        chk("t2_rvalid", m0_bus.rvalid, 1'b1);
        chk("t2_rdata", m0_bus.rdata, 32'hA5A5A5A5);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Constant collisions without lock.
        p1_cnt = 0;
        drive(0, 1'b1, 1'b1, 1'b0, 9'd10, 32'h1111_0000);
        drive(1, 1'b1, 1'b1, 1'b0, 9'd11, 32'h2222_0000);
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (obs_g1) p1_cnt++;
        end
`ifdef DMEM_ARB_RR_EN
        chk("t3_p1_grants", p1_cnt, 2);
`else
        chk("t3_p1_grants", p1_cnt, 0);
`endif
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Port 1 locked burst longer than LOCK_MAX while port 0 keeps requesting.
        p1_cnt = 0;
        drive(1, 1'b1, 1'b0, 1'b1, 9'd10, '0);
        cycle();
        if (obs_g1) p1_cnt++;
        drive(0, 1'b1, 1'b0, 1'b0, 9'd11, '0);
        p0_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (obs_g1) p1_cnt++;
            if (obs_g0) p0_cnt++;
        end
        chk("t4_p1_grants", p1_cnt, LOCK_MAX);
        chk("t4_p0_after_release", obs_g0, 1'b1);
        chk("t4_p0_grants", p0_cnt, 1);
        cycle();
`ifdef DMEM_ARB_RR_EN
        chk("t4_relock_owner", owner, 2'b10);
`else
        chk("t4_relock_owner", owner, 2'b00);
`endif
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < LOCK_MAX; i++) cycle();

        // Port 1 single access so port 0 wins the next collision in both modes.
        drive(1, 1'b1, 1'b1, 1'b0, 9'd20, 32'hCAFE_0001);
        cycle();
        // Port 0 burst of three (lock,lock,unlock) with port 1 pending.
        drive(0, 1'b1, 1'b1, 1'b1, 9'd21, 32'h0000_0021);
        drive(1, 1'b1, 1'b0, 1'b0, 9'd21, '0);
        cycle();
        chk("t5_g0_first", obs_g0, 1'b1);
        chk("t5_owner1", owner, 2'b01);
        drive(0, 1'b1, 1'b1, 1'b1, 9'd22, 32'h0000_0022);
        cycle();
        chk("t5_owner2", owner, 2'b01);
        drive(0, 1'b1, 1'b0, 1'b0, 9'd22, '0);
        cycle();
        chk("t5_owner_idle", owner, 2'b00);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("t5_p1_granted", obs_g1, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Reset pulse during OWN0 right after a read grant.
        drive(0, 1'b1, 1'b0, 1'b1, 9'd21, '0);
        cycle();
        chk("t6_owner_before", owner, 2'b01);
        resetn = 1'b0;
        #1;
        chk("t6_owner_rst", owner, 2'b00);
        chk("t6_rvalid_rst", m0_bus.rvalid, 1'b0);
        model_reset();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle();
        resetn = 1'b1;
        cycle();
        drive(0, 1'b1, 1'b0, 1'b0, 9'd5, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 9'd20, '0);
        cycle();
        chk("t6_first_arb", obs_g0, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle();
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Random traffic; each requester holds its request until the model says it was granted.
        for (int i = 0; i < 600; i++) begin
            if (!m0_bus.req || mg0)
                drive(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2) == 0, 9'($urandom_range(0, 15)), $urandom);
            if (!m1_bus.req || mg1)
                drive(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2) == 0, 9'($urandom_range(0, 15)), $urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
